activity_scanner: RTL and testbench
===================================

Name: activity_scanner

Overview:
- Double-buffered 256-entry neuron activity bitmap, feeding the core's activity-driven processing stage.
- Accumulates "neuron became active" marks during a timestep.
- On scan_start, swaps banks and emits every marked neuron ID downstream via valid/ready, highest ID first.
- ID selection uses two levels of the team's 16->4 find-set-bit priority encoder: group mask, then word.

Parameters:
- NUM_GROUPS, 16, number of 16-bit activity words (1..16); valid IDs are 0 .. NUM_GROUPS*16-1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of both banks and the FSM.
- set_valid  input  1  mark set_id active in the accumulate bank.
- set_id  input  8  neuron ID to mark.
- scan_start  input  1  request to swap banks and scan; honoured only in IDLE.
- busy  output  1  high in SCAN and DONE.
- out_valid  output  1  out_id is valid.
- out_id  output  8  active neuron ID, {group[3:0], bit[3:0]}.
- out_ready  input  1  consumer accepts out_id.
- scan_done  output  1  one-cycle pulse at end of scan.

Behaviour:
- Reset (reset_n low, asynchronous): both banks zero, bank select 0, state IDLE, busy 0, out_valid 0, out_id 0, scan_done 0.
- Storage: two banks of NUM_GROUPS x 16 bits. Bank select marks one bank as accumulate and the other as scan. Each bank keeps a NUM_GROUPS-bit group-nonempty mask alongside its words.
- Set path, any state:
  - set_valid with set_id < NUM_GROUPS*16 sets that bit in the accumulate bank.
  - Duplicate sets are idempotent.
  - Out-of-range IDs are dropped.
- FSM:
  - IDLE: scan_start moves to SCAN and toggles bank select. The former accumulate bank becomes the scan bank; the new accumulate bank is already empty.
  - SCAN: if the scan bank is nonempty, out_valid=1 and out_id={g,b}. g is the highest nonempty group; b is the highest set bit in word g.
    - On out_valid&&out_ready, clear that bit and update the group mask.
    - One ID per cycle while out_ready is held high.
    - If the scan bank is empty, go to DONE.
  - DONE: scan_done=1 for one cycle, then IDLE.
- out_valid and out_id are combinational from the registered scan bank and state. The scan bank changes only on handshake, so out_id is stable while out_valid && !out_ready.
- out_ready while out_valid=0 has no effect.
- Latency: scan_start in cycle N gives SCAN in N+1.
  - k IDs with ready held high: IDs in N+1..N+k, empty SCAN in N+k+1, scan_done in N+k+2.
  - Empty scan: scan_done in N+2.
- Set in the same cycle as an accepted scan_start lands in the new accumulate bank (next timestep). Sets during SCAN/DONE likewise go to the accumulate bank. A scan never sees marks made after its start.
- scan_start outside IDLE is ignored, not queued.
- clear has priority over set, scan_start and handshake:
  - Next cycle: both banks are zero, state is IDLE, out_valid is 0, and no scan_done pulse is produced.
  - Bank select is unchanged.
- Asserting reset_n low mid-scan aborts immediately; no partial scan_done.

Optional Feature:
- Macro: UCASPIAN_ACTIVITY_COUNT_EN.
- Defined: adds output scan_count (9 bits).
  - Counts handshakes during the current scan.
  - Zeroed when a scan starts (IDLE to SCAN), on clear and on reset.
  - Holds its final value from the scan_done cycle until the next scan starts.
  - Also adds output set_overflow (1 bit): sticky, set by an out-of-range set_id, cleared by clear or reset.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, set IDs 3, 200, 17, 200, then scan_start with out_ready=1 -> out_id 200, 17, 3 on consecutive cycles; scan_done 2 cycles after the last ID; count=3.
- scan_start with empty bitmap -> no out_valid; scan_done exactly 2 cycles after scan_start; busy high for those 2 cycles.
- Set 5 and 6, scan, hold out_ready=0 for 4 cycles -> out_valid=1 with out_id=6 stable throughout; release -> 6, then 5.
- During a scan of {10}, set 10 and 40 -> current scan emits only 10; next scan_start emits 40 then 10.
- Mid-scan of {1,2,3} after one handshake, pulse clear -> out_valid 0 next cycle, no scan_done, IDLE; next scan emits nothing.
- With NUM_GROUPS=4, set_id 64 -> ignored; set_overflow=1 when UCASPIAN_ACTIVITY_COUNT_EN is defined. Drop reset_n mid-scan -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/activity_scanner.sv
// -----------------------------------------------------------------------------
// activity_scanner
//
// Double-buffered neuron activity bitmap. Marks made during a timestep go into
// the accumulate bank. scan_start swaps the banks, and the scan bank is then
// drained downstream as neuron IDs over valid/ready, highest ID first. Each ID
// is found by two 16->4 find-highest-set-bit encodes: first over the
// group-nonempty mask, then over the selected 16-bit word.
//
// Parameters:
//   NUM_GROUPS  number of 16-bit activity words (1..16); IDs 0..NUM_GROUPS*16-1
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   clear          synchronous flush of both banks and the FSM
//   set_valid      mark set_id in the accumulate bank (out-of-range IDs dropped)
//   set_id[7:0]    neuron ID to mark
//   scan_start     swap banks and scan; honoured only while idle
//   busy           high while scanning and during the done cycle
//   out_valid      out_id holds an active neuron ID
//   out_id[7:0]    {group[3:0], bit[3:0]}
//   out_ready      consumer accepts out_id
//   scan_done      one-cycle pulse at the end of a scan
//
// Optional build macro UCASPIAN_ACTIVITY_COUNT_EN adds:
//   scan_count[8:0]  handshakes in the current or most recent scan
//   set_overflow     sticky flag for an out-of-range set_id
// -----------------------------------------------------------------------------
module activity_scanner #(
  parameter int NUM_GROUPS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       set_valid,
  input  logic [7:0] set_id,
  input  logic       scan_start,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] out_id,
  input  logic       out_ready,
  output logic       scan_done
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
  ,
  output logic [8:0] scan_count,
  output logic       set_overflow
`endif
);

  localparam logic [8:0] NUM_IDS = 9'(NUM_GROUPS * 16);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  // 16->4 find-set-bit priority encoder: index of the highest set bit.
  function automatic logic [3:0] find_msb16(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;          // index of the accumulate bank
  logic [15:0]           word_q [2][NUM_GROUPS];
  logic [15:0]           word_d [2][NUM_GROUPS];
  logic [NUM_GROUPS-1:0] mask_q [2];
  logic [NUM_GROUPS-1:0] mask_d [2];

  logic        scan_bank;
  logic [15:0] scan_mask16;
  logic [15:0] scan_word;
  logic [3:0]  scan_grp;
  logic [3:0]  scan_bit;
  logic        scan_nonempty;
  logic        set_in_range;
  logic        accept;

  assign scan_bank     = ~sel_q;
  assign scan_nonempty = |mask_q[scan_bank];
  assign set_in_range  = {1'b0, set_id} < NUM_IDS;
  assign accept        = out_valid && out_ready && !clear;

  // Highest nonempty group, then highest set bit within that group's word.
  always_comb begin
    scan_mask16                 = '0;
    scan_mask16[NUM_GROUPS-1:0] = mask_q[scan_bank];
    scan_grp                    = find_msb16(scan_mask16);
    scan_word                   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (4'(g) == scan_grp) scan_word = word_q[scan_bank][g];
    end
    scan_bit = find_msb16(scan_word);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (scan_start) begin
          state_d = S_SCAN;
          sel_d   = ~sel_q;
        end
        S_SCAN: if (!scan_nonempty) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    scan_done = (state_q == S_DONE);
    out_valid = (state_q == S_SCAN) && scan_nonempty;
    out_id    = out_valid ? {scan_grp, scan_bit} : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // Bitmap banks. Sets target sel_d so a set accepted alongside scan_start
  // lands in the new accumulate bank. The scan bank only changes on handshake,
  // which keeps out_id stable while the consumer stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    if (clear) begin
      for (int b = 0; b < 2; b++) begin
        mask_d[b] = '0;
        for (int g = 0; g < NUM_GROUPS; g++) word_d[b][g] = '0;
      end
    end else begin
      if (set_valid && set_in_range) begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
          if (4'(g) == set_id[7:4]) begin
            word_d[sel_d][g][set_id[3:0]] = 1'b1;
            mask_d[sel_d][g]              = 1'b1;
          end
        end
      end
      // Handshakes only occur in SCAN, where sel_d == sel_q, so this never
      // touches the bank written by the set path above.
      if (accept) begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
          if (4'(g) == scan_grp) begin
            word_d[scan_bank][g][scan_bit] = 1'b0;
            mask_d[scan_bank][g]           = |word_d[scan_bank][g];
          end
        end
      end
    end
  end

  // NOTE: the banks are reset explicitly: an idle scan bank must read empty,
  // so the bitmap cannot be left as uninitialised RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        mask_q[b] <= '0;
        for (int g = 0; g < NUM_GROUPS; g++) word_q[b][g] <= '0;
      end
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end

`ifdef UCASPIAN_ACTIVITY_COUNT_EN
  logic [8:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (state_q == S_IDLE && scan_start) count_d = '0;
      else if (accept)                     count_d = count_q + 9'd1;
      if (set_valid && !set_in_range)      ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign scan_count   = count_q;
  assign set_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_activity_scanner.sv
// -----------------------------------------------------------------------------
// tb_activity_scanner
//
// Directed bench for activity_scanner. u_dut (16 groups) runs the main
// sequences; stimulus pushes the expected ID stream into exp_q and a negedge
// monitor pops and compares on every handshake. Timing (out_valid, busy,
// scan_done) is checked cycle by cycle against hand-derived timelines.
// u_dut4 (4 groups) covers out-of-range set IDs.
// -----------------------------------------------------------------------------
module tb_activity_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       set_valid;
  logic [7:0] set_id;
  logic       scan_start;
  logic       out_ready;
  logic       busy, out_valid, scan_done;
  logic [7:0] out_id;

  logic       set_valid4, scan_start4, out_ready4;
  logic [7:0] set_id4;
  logic       busy4, out_valid4, scan_done4;
  logic [7:0] out_id4;

`ifdef UCASPIAN_ACTIVITY_COUNT_EN
  logic [8:0] scan_count, scan_count4;
  logic       set_overflow, set_overflow4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  activity_scanner #(.NUM_GROUPS(16)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .set_valid  (set_valid),
    .set_id     (set_id),
    .scan_start (scan_start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .scan_done  (scan_done)
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    ,
    .scan_count   (scan_count),
    .set_overflow (set_overflow)
`endif
  );

  activity_scanner #(.NUM_GROUPS(4)) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .set_valid  (set_valid4),
    .set_id     (set_id4),
    .scan_start (scan_start4),
    .busy       (busy4),
    .out_valid  (out_valid4),
    .out_id     (out_id4),
    .out_ready  (out_ready4),
    .scan_done  (scan_done4)
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    ,
    .scan_count   (scan_count4),
    .set_overflow (set_overflow4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted ID must match the next expected one.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_id", {24'd0, out_id}, 32'hFFFF_FFFF);
      end else begin
        check("sb_out_id", {24'd0, out_id}, exp_q.pop_front());
      end
    end
  end

  // Advance one cycle; return 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_one(input logic [7:0] id);
    set_valid = 1'b1;
    set_id    = id;
    cyc();
    set_valid = 1'b0;
  endtask

  // Returns in cycle N+1 of a scan_start issued in cycle N.
  task automatic start_scan();
    scan_start = 1'b1;
    cyc();
    scan_start = 1'b0;
  endtask

  // With out_ready high and k IDs left, starting in the first ID cycle:
  // IDs for k cycles, one empty SCAN cycle, DONE, then IDLE.
  task automatic timeline(input int k);
    for (int t = 1; t <= k + 3; t++) begin
      check("tl_out_valid", {31'd0, out_valid}, {31'd0, t <= k});
      check("tl_busy",      {31'd0, busy},      {31'd0, t <= k + 2});
      check("tl_scan_done", {31'd0, scan_done}, {31'd0, t == k + 2});
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    set_valid   = 1'b0;
    set_id      = '0;
    scan_start  = 1'b0;
    out_ready   = 1'b0;
    set_valid4  = 1'b0;
    set_id4     = '0;
    scan_start4 = 1'b0;
    out_ready4  = 1'b0;

    // Reset state.
    #12;
    check("rst_busy",      {31'd0, busy},      0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_id",    {24'd0, out_id},    0);
    check("rst_scan_done", {31'd0, scan_done}, 0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // 1: sets 3, 200, 17, 200 -> 200, 17, 3 back to back.
    set_one(8'd3);
    set_one(8'd200);
    set_one(8'd17);
    set_one(8'd200);
    exp_q.push_back(200);
    exp_q.push_back(17);
    exp_q.push_back(3);
    out_ready = 1'b1;
    start_scan();
    timeline(3);
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    check("t1_scan_count", {23'd0, scan_count}, 3);
`endif

    // 2: empty bitmap -> scan_done two cycles after scan_start.
    start_scan();
    timeline(0);

    // 3: consumer stalls for 4 cycles; out_id must hold at 6.
    set_one(8'd5);
    set_one(8'd6);
    out_ready = 1'b0;
    exp_q.push_back(6);
    exp_q.push_back(5);
    start_scan();
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_valid", {31'd0, out_valid}, 1);
      check("t3_stall_id",    {24'd0, out_id},    6);
      cyc();
    end
    out_ready = 1'b1;
    timeline(2);
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    check("t3_scan_count", {23'd0, scan_count}, 2);
`endif

    // 4: sets during a scan of {10} go to the next timestep.
    set_one(8'd10);
    exp_q.push_back(10);
    start_scan();
    check("t4_valid_10", {31'd0, out_valid}, 1);
    set_valid = 1'b1;
    set_id    = 8'd10;
    cyc();
    set_id    = 8'd40;
    check("t4_only_10", {31'd0, out_valid}, 0);
    cyc();
    set_valid = 1'b0;
    check("t4_done", {31'd0, scan_done}, 1);
    cyc();
    check("t4_idle", {31'd0, busy}, 0);
    // Next scan emits 40, 10; a set alongside scan_start waits one more scan.
    exp_q.push_back(40);
    exp_q.push_back(10);
    set_valid  = 1'b1;
    set_id     = 8'd99;
    start_scan();
    set_valid  = 1'b0;
    timeline(2);
    exp_q.push_back(99);
    start_scan();
    timeline(1);

    // 5: clear mid-scan of {1,2,3} after one handshake.
    set_one(8'd1);
    set_one(8'd2);
    set_one(8'd3);
    exp_q.push_back(3);
    start_scan();
    cyc();
    out_ready = 1'b0;
    check("t5_valid_2", {31'd0, out_valid}, 1);
    check("t5_id_2",    {24'd0, out_id},    2);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("t5_clr_valid", {31'd0, out_valid}, 0);
    check("t5_clr_busy",  {31'd0, busy},      0);
    check("t5_clr_done",  {31'd0, scan_done}, 0);
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    check("t5_clr_count", {23'd0, scan_count}, 0);
`endif
    cyc();
    check("t5_no_done", {31'd0, scan_done}, 0);
    out_ready = 1'b1;
    start_scan();
    timeline(0);

    // 6a: 4-group instance drops set_id 64, keeps 63.
    out_ready4 = 1'b1;
    set_valid4 = 1'b1;
    set_id4    = 8'd64;
    cyc();
    set_id4    = 8'd63;
    cyc();
    set_valid4 = 1'b0;
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    check("t6_overflow", {31'd0, set_overflow4}, 1);
    check("t6_no_ovf16", {31'd0, set_overflow},  0);
`endif
    scan_start4 = 1'b1;
    cyc();
    scan_start4 = 1'b0;
    check("t6_g4_valid", {31'd0, out_valid4}, 1);
    check("t6_g4_id",    {24'd0, out_id4},    63);
    cyc();
    check("t6_g4_drop64", {31'd0, out_valid4}, 0);
    check("t6_g4_busy",   {31'd0, busy4},      1);
    cyc();
    check("t6_g4_done", {31'd0, scan_done4}, 1);

    // 6b: reset_n dropped mid-scan clears outputs without waiting for a clock.
    set_one(8'd7);
    set_one(8'd8);
    out_ready = 1'b0;
    start_scan();
    check("t6_pre_valid", {31'd0, out_valid}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 0);
    check("t6_rst_id",    {24'd0, out_id},    0);
    check("t6_rst_busy",  {31'd0, busy},      0);
    check("t6_rst_done",  {31'd0, scan_done}, 0);
`ifdef UCASPIAN_ACTIVITY_COUNT_EN
    check("t6_rst_ovf", {31'd0, set_overflow4}, 0);
`endif
    cyc();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cyc();
    check("t6_post_done", {31'd0, scan_done}, 0);
    start_scan();
    timeline(0);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
